// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_pkg
// Description : Shared definitions for the byte-stream memory loader:
//               default parameter values, header field sizes, FSM state
//               encoding and the frame bounds-check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_loader_pkg;

  localparam int         MEM_DEPTH_DEFAULT = 3000;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Header field sizes, in bytes
  localparam int ADDR_BYTES = 4;
  localparam int LEN_BYTES  = 2;

  // Loader FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_ADDR = 3'd1;
  localparam state_t ST_LEN  = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_CSUM = 3'd4;
  localparam state_t ST_FIN  = 3'd5;
  localparam state_t ST_FAIL = 3'd6;

  // True when [addr, addr+len) lies inside memory. Evaluated at 33 bits so
  // that a start address near 2^32 cannot wrap around and look in-range.
  function automatic logic frame_fits(input logic [31:0] addr,
                                      input logic [15:0] len,
                                      input int          depth);
    logic [32:0] w_end;
    w_end = {1'b0, addr} + {17'b0, len};
    return (w_end <= 33'(depth));
  endfunction

endpackage : mem_loader_pkg
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Receives framed bytes over a valid/ready stream and writes
//               the payload into unified memory while holding the CPU in
//               reset. Frame: SYNC, addr[4] (LSB first), len[2] (LSB first),
//               len data bytes, optional checksum byte.
// Config      : LOADER_CHECKSUM_EN - when defined, a trailing 8-bit
//               additive checksum byte is expected and verified.
// Ports       : CLOCK_50  - clock, rising edge
//               KEY0      - asynchronous active-low reset
//               in_valid / in_data / in_ready - byte stream handshake
//               mem_we / mem_addr / mem_wdata - byte write port
//               cpu_hold  - holds CPU in reset during a load
//               done / err - sticky completion / failure flags
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int         MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] c_addr_last = 3'(ADDR_BYTES - 1);
  localparam logic [2:0] c_len_last  = 3'(LEN_BYTES - 1);

  // Where the FSM goes once the payload is exhausted
`ifdef LOADER_CHECKSUM_EN
  localparam state_t c_after_data = ST_CSUM;
`else
  localparam state_t c_after_data = ST_FIN;
`endif

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_addr;
  logic [7:0]  r_len_lo;
  logic [15:0] r_rem;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  logic        w_fire;
  logic [15:0] w_len;

  // FIN and FAIL are single bookkeeping cycles; nothing is accepted there
  assign in_ready = (r_state != ST_FIN) && (r_state != ST_FAIL);
  assign w_fire   = in_valid && in_ready;
  // Full length as it will be once the current (MSB) byte is captured
  assign w_len    = {in_data, r_len_lo};

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_addr      <= 32'd0;
      r_len_lo    <= 8'd0;
      r_rem       <= 16'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 8'd0;
      r_cpu_hold  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum       <= 8'd0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire && (in_data == SYNC_BYTE)) begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_cnt      <= 3'd0;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= 8'd0;
`endif
            r_state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_fire) begin
            // LSB arrives first, so shift new bytes in from the top
            r_addr <= {in_data, r_addr[31:8]};
            if (r_cnt == c_addr_last) begin
              r_cnt   <= 3'd0;
              r_state <= ST_LEN;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        ST_LEN: begin
          if (w_fire) begin
            r_len_lo <= in_data;
            if (r_cnt == c_len_last) begin
              r_cnt <= 3'd0;
              r_rem <= w_len;
              if (!frame_fits(r_addr, w_len, MEM_DEPTH)) begin
                r_state <= ST_FAIL;
              end else if (w_len == 16'd0) begin
                r_state <= c_after_data;
              end else begin
                r_state <= ST_DATA;
              end
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_fire) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= in_data;
            r_addr      <= r_addr + 32'd1;
            r_rem       <= r_rem - 16'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= r_sum + in_data;
`endif
            if (r_rem == 16'd1) begin
              r_state <= c_after_data;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (w_fire) begin
            r_state <= (in_data == r_sum) ? ST_FIN : ST_FAIL;
          end
        end
`endif
        ST_FIN: begin
          r_done     <= 1'b1;
          r_cpu_hold <= 1'b0;
          r_state    <= ST_IDLE;
        end
        ST_FAIL: begin
          // CPU stays held: memory contents are only partially loaded
          r_err   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign err       = r_err;

endmodule : mem_loader
`default_nettype wire

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
- REQ-001 Parameter MEM_DEPTH, default 3000: number of bytes in unified memory; the loader never writes addresses >= MEM_DEPTH.
- REQ-002 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
- REQ-003 CLOCK_50  input  1: sole clock, 50 MHz, rising edge.
- REQ-004 KEY0  input  1: reset, asynchronous, active-low.
- REQ-005 in_valid  input  1: byte-stream source has a byte.
- REQ-006 in_data  input  8: byte-stream data.
- REQ-007 in_ready  output  1: loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both high.
- REQ-008 mem_we  output  1: one-cycle byte write strobe to unified memory.
- REQ-009 mem_addr  output  32: byte write address.
- REQ-010 mem_wdata  output  8: byte write data.
- REQ-011 cpu_hold  output  1: holds the CPU fetch/PC logic in reset while a frame loads.
- REQ-012 done  output  1: sticky flag; last frame completed without error.
- REQ-013 err  output  1: sticky flag; last frame aborted or failed its checksum.

Function
- REQ-014 The frame format SHALL be: SYNC_BYTE, then 4-byte start address (LSB first), then 2-byte length N (LSB first), then N data bytes, then a 1-byte checksum.
- REQ-015 The state machine SHALL have the states IDLE, ADDR, LEN, DATA, CSUM, FIN and FAIL.
- REQ-016 IDLE: an accepted byte equal to SYNC_BYTE SHALL clear done/err, set cpu_hold, clear the byte counter and go to ADDR; any other byte SHALL be discarded.
- REQ-017 ADDR: the loader SHALL shift in 4 bytes and then go to LEN.
- REQ-018 LEN: after 2 bytes, it SHALL go to FAIL if addr+N > MEM_DEPTH (computed at 33 bits, no wrap), to CSUM if N==0, and to DATA otherwise.
- REQ-019 DATA: each accepted byte SHALL, in the next cycle, drive mem_we=1, mem_addr=current address and mem_wdata=byte; the address SHALL then increment by 1.
- REQ-020 DATA: the running checksum SHALL be the 8-bit sum modulo 256 of the data bytes, initialised to 0.
- REQ-021 DATA: after the Nth byte, the state machine SHALL go to CSUM.
- REQ-022 CSUM: an accepted byte equal to the running sum SHALL go to FIN, and any other byte SHALL go to FAIL.
- REQ-023 FIN SHALL last one cycle, set done=1, clear cpu_hold and return to IDLE.
- REQ-024 FAIL SHALL last one cycle, set err=1, keep cpu_hold=1 and return to IDLE.
- REQ-025 in_ready SHALL be 1 in IDLE, ADDR, LEN, DATA and CSUM, and 0 in FIN and FAIL.
- REQ-026 Latency: mem_we SHALL assert exactly 1 cycle after the data byte is accepted, and there SHALL be at most one write in flight.
- REQ-027 Back-to-back bytes (in_valid held high) SHALL be accepted every cycle with no stall.
- REQ-028 A SYNC_BYTE value received inside ADDR, LEN, DATA or CSUM SHALL be treated as ordinary data.
- REQ-029 Bytes already written before a FAIL SHALL remain written; there is no rollback.

Reset
- REQ-030 With KEY0 low, the block SHALL asynchronously enter IDLE with mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0, in_ready=1, counters=0 and checksum=0.
- REQ-031 On reset mid-frame, the block SHALL abandon the frame immediately, and a pending write SHALL NOT be issued.

Configuration
- REQ-032 Macro LOADER_CHECKSUM_EN defined: CSUM state present as in REQ-022.
- REQ-033 Macro LOADER_CHECKSUM_EN undefined: CSUM state and checksum register SHALL be absent; after the Nth data byte (or at LEN with N==0) the state machine SHALL go directly to FIN, and the frame SHALL carry no checksum byte.

Structure
- REQ-034 Package mem_loader_pkg SHALL hold the state enum, the SYNC_BYTE default, the MEM_DEPTH default and the header byte counts (ADDR_BYTES=4, LEN_BYTES=2).
- REQ-035 There SHALL be no sub-module; a single FSM with a datapath is sufficient.

Verification
- REQ-036 Frame A5 10 00 00 00 03 00 11 22 33 66 -> writes 11/22/33 to addresses 16/17/18, one per cycle each 1 cycle after acceptance; done=1, err=0, cpu_hold falls.
- REQ-037 Same frame with checksum 67 -> three writes occur, err=1, done=0, cpu_hold stays 1.
- REQ-038 Header with addr=2998 and N=3 -> FAIL after the second length byte, no mem_we, err=1.
- REQ-039 N=0 frame A5 00 00 00 00 00 00 00 -> no writes, done=1; without the macro, no checksum byte is sent and done=1.
- REQ-040 Garbage bytes 00 FF 12 followed by a valid frame -> garbage is ignored, the frame loads correctly, and in_ready is 0 for exactly the FIN cycle.
- REQ-041 KEY0 pulsed low after the 2nd data byte -> outputs return to reset values, no third write occurs, and the next frame loads normally.
